// File: rtl/func_bist_ctrl_if.sv
// Signal bundle between the functional BIST sequencer, the 3-input function unit it exercises and its host.
// master: the sequencer itself; slave: the host/function-unit side.
interface func_bist_ctrl_if;
    logic       start;
    logic       func_a;
    logic       func_b;
    logic       func_c;
    logic       func_f;
    logic       busy;
    logic       done;
    logic [7:0] tt_out;
    logic [3:0] ones_count;
    logic       pass;
    logic       fail_valid;
    logic [2:0] fail_idx;

    modport master (
        input  start,
        input  func_f,
        output func_a,
        output func_b,
        output func_c,
        output busy,
        output done,
        output tt_out,
        output ones_count,
        output pass,
        output fail_valid,
        output fail_idx
    );

    modport slave (
        output start,
        output func_f,
        input  func_a,
        input  func_b,
        input  func_c,
        input  busy,
        input  done,
        input  tt_out,
        input  ones_count,
        input  pass,
        input  fail_valid,
        input  fail_idx
    );
endinterface

// File: rtl/func_bist_ctrl.sv
// Functional BIST sequencer: sweeps all 8 vectors through a 3-input function unit, captures its truth table
// and compares it with EXP_TT. Optional macro FUNC_BIST_STOP_ON_FAIL_EN aborts the sweep on the first mismatch.
module func_bist_ctrl #(
    parameter logic [3:0] SETTLE_CYCLES = 4'd1,
    parameter logic [7:0] EXP_TT        = 8'b0110_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    func_bist_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [7:0]  tt_r;
    logic [7:0]  tt_s;
    logic [3:0]  ones_r;
    logic [3:0]  ones_s;
    logic        pass_r;
    logic        pass_s;
    logic        fail_valid_r;
    logic        fail_valid_s;
    logic [2:0]  fail_idx_r;
    logic [2:0]  fail_idx_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;
    logic        mismatch_s;

    // Next-state and next-result logic for the sweep sequencer.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        tt_s         = tt_r;
        ones_s       = ones_r;
        pass_s       = pass_r;
        fail_valid_s = fail_valid_r;
        fail_idx_s   = fail_idx_r;
        mismatch_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s      = ST_SETTLE;
                    idx_s        = 3'd0;
                    cnt_s        = SETTLE_CYCLES;
                    tt_s         = 8'd0;
                    ones_s       = 4'd0;
                    pass_s       = 1'b0;
                    fail_valid_s = 1'b0;
                    fail_idx_s   = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_SAMPLE: begin
                mismatch_s = (bus.func_f != EXP_TT[idx_r]);
                if (mismatch_s && !fail_valid_r) begin
                    fail_valid_s = 1'b1;
                    fail_idx_s   = idx_r;
                end else begin
                    fail_valid_s = fail_valid_r;
                end
`ifdef FUNC_BIST_STOP_ON_FAIL_EN
                // The aborting vector is reported through fail_idx only; the table keeps the vectors that matched.
                if (mismatch_s) begin
                    state_s = ST_DONE;
                end else begin
                    tt_s[idx_r] = bus.func_f;
                    ones_s      = ones_r + {3'b000, bus.func_f};
                    if (idx_r == 3'd7) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        cnt_s   = SETTLE_CYCLES;
                        state_s = ST_SETTLE;
                    end
                end
`else
                tt_s[idx_r] = bus.func_f;
                ones_s      = ones_r + {3'b000, bus.func_f};
                if (idx_r == 3'd7) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = idx_r + 3'd1;
                    cnt_s   = SETTLE_CYCLES;
                    state_s = ST_SETTLE;
                end
`endif
            end
            ST_DONE: begin
                pass_s  = (tt_r == EXP_TT) && !fail_valid_r;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
        done_s = (state_s == ST_DONE);
    end

    // State and result registers; outputs are taken straight from these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            cnt_r        <= 4'd0;
            tt_r         <= 8'd0;
            ones_r       <= 4'd0;
            pass_r       <= 1'b0;
            fail_valid_r <= 1'b0;
            fail_idx_r   <= 3'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            tt_r         <= tt_s;
            ones_r       <= ones_s;
            pass_r       <= pass_s;
            fail_valid_r <= fail_valid_s;
            fail_idx_r   <= fail_idx_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign bus.func_a     = idx_r[2];
    assign bus.func_b     = idx_r[1];
    assign bus.func_c     = idx_r[0];
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.tt_out     = tt_r;
    assign bus.ones_count = ones_r;
    assign bus.pass       = pass_r;
    assign bus.fail_valid = fail_valid_r;
    assign bus.fail_idx   = fail_idx_r;

endmodule

// File: tb/tb_func_bist_ctrl.sv
// Self-checking bench for func_bist_ctrl: a cycle-count based model of the sweep plus directed scenarios
// with hand-computed results (correct unit, stuck-at-0, vector-3 fault, mid-sweep reset, start handling).
module tb_func_bist_ctrl;
    localparam logic [3:0] SETTLE = 4'd1;
    localparam int         SLOT   = int'(SETTLE) + 2;
`ifdef FUNC_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] unit_tt;
    logic [7:0] exp_tt = 8'h61;
    int         errors = 0;
    int         checks = 0;
    int         n_done = 0;

    // Model: m_k counts cycles since the accepting edge (0 = no sweep), done is due in cycle m_len.
    int         m_k    = 0;
    int         m_len  = 0;
    int         m_ones = 0;
    int         m_fidx = 0;
    int         m_vec  = 0;
    logic [7:0] m_tt   = 8'd0;
    logic       m_fv   = 1'b0;
    logic       m_pass = 1'b0;

    func_bist_ctrl_if bus ();

    // The function unit under test: a lookup table addressed by {A,B,C}.
    assign bus.func_f = unit_tt[{bus.func_a, bus.func_b, bus.func_c}];

    func_bist_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .EXP_TT        (8'h61)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: vector v is sampled in cycle (v+1)*SLOT, done follows the last sample.
    always @(posedge clk or negedge rst_n) begin : model_b
        int         k, len, v, ones, fidx, vec;
        logic [7:0] t;
        logic       fv, pass, f;
        if (!rst_n) begin
            m_k <= 0; m_len <= 0; m_ones <= 0; m_fidx <= 0; m_vec <= 0;
            m_tt <= 8'd0; m_fv <= 1'b0; m_pass <= 1'b0;
        end else begin
            k = m_k; len = m_len; ones = m_ones; fidx = m_fidx; vec = m_vec;
            t = m_tt; fv = m_fv; pass = m_pass;
            if (k == 0) begin
                if (bus.start) begin
                    k = 1; len = 8 * SLOT + 1; ones = 0; fidx = 0; vec = 0;
                    t = 8'd0; fv = 1'b0; pass = 1'b0;
                end
            end else if (k == len) begin
                pass = (t == exp_tt) && !fv;
                k = 0;
            end else begin
                if (k % SLOT == 0) begin
                    v = k / SLOT - 1;
                    f = unit_tt[v];
                    if (f != exp_tt[v] && !fv) begin
                        fv = 1'b1;
                        fidx = v;
                    end
                    if (STOP && f != exp_tt[v]) begin
                        len = k + 1;
                    end else begin
                        t[v] = f;
                        ones = ones + int'(f);
                        if (v < 7) vec = v + 1;
                    end
                end
                k = k + 1;
            end
            m_k <= k; m_len <= len; m_ones <= ones; m_fidx <= fidx; m_vec <= vec;
            m_tt <= t; m_fv <= fv; m_pass <= pass;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("busy",       32'(bus.busy),       32'(m_k >= 1 && m_k < m_len));
        check("done",       32'(bus.done),       32'(m_k != 0 && m_k == m_len));
        check("vector",     32'({bus.func_a, bus.func_b, bus.func_c}), 32'(m_vec));
        check("tt_out",     32'(bus.tt_out),     32'(m_tt));
        check("ones_count", 32'(bus.ones_count), 32'(m_ones));
        check("fail_valid", 32'(bus.fail_valid), 32'(m_fv));
        check("fail_idx",   32'(bus.fail_idx),   32'(m_fv ? m_fidx : 0));
        check("pass",       32'(bus.pass),       32'(m_pass));
        if (bus.done) n_done <= n_done + 1;
    end

    // One sweep from IDLE; optionally re-pulses start in cycle poke_at. Entered and left at negedge+2.
    task automatic run_sweep(input string tag, input int e_lat, input logic [7:0] e_tt,
                             input logic [3:0] e_ones, input logic e_fv, input logic [2:0] e_fidx,
                             input logic e_pass, input int poke_at);
        int lat;
        lat = 0;
        bus.start = 1'b1;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.done) lat = c;
            #2 bus.start = (c == poke_at) ? 1'b1 : 1'b0;
        end
        check({tag, " latency"},    32'(lat),            32'(e_lat));
        check({tag, " tt_out"},     32'(bus.tt_out),     32'(e_tt));
        check({tag, " ones_count"}, 32'(bus.ones_count), 32'(e_ones));
        check({tag, " fail_valid"}, 32'(bus.fail_valid), 32'(e_fv));
        if (e_fv) check({tag, " fail_idx"}, 32'(bus.fail_idx), 32'(e_fidx));
        @(negedge clk);
        #2 bus.start = 1'b0;
        check({tag, " pass"}, 32'(bus.pass), 32'(e_pass));
        @(negedge clk);
        #2;
        check({tag, " idle after done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int first, second, seen;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        unit_tt   = 8'h61;
        repeat (2) @(negedge clk);
        check("reset busy",       32'(bus.busy),       32'd0);
        check("reset done",       32'(bus.done),       32'd0);
        check("reset vector",     32'({bus.func_a, bus.func_b, bus.func_c}), 32'd0);
        check("reset tt_out",     32'(bus.tt_out),     32'd0);
        check("reset ones_count", 32'(bus.ones_count), 32'd0);
        check("reset pass",       32'(bus.pass),       32'd0);
        check("reset fail_valid", 32'(bus.fail_valid), 32'd0);
        check("reset fail_idx",   32'(bus.fail_idx),   32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #2;

        unit_tt = 8'h61;
        run_sweep("correct", 25, 8'h61, 4'd3, 1'b0, 3'd0, 1'b1, 0);

        unit_tt = 8'h00;
        run_sweep("stuck0", STOP ? 4 : 25, 8'h00, 4'd0, 1'b1, 3'd0, 1'b0, 0);

        unit_tt = 8'h69;
        run_sweep("v3 fault", STOP ? 13 : 25, STOP ? 8'h01 : 8'h69, STOP ? 4'd1 : 4'd4,
                  1'b1, 3'd3, 1'b0, 0);

        // Reset while vector 4 is driven.
        unit_tt = 8'h61;
        bus.start = 1'b1;
        @(negedge clk);
        #2 bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("mid-sweep vector", 32'({bus.func_a, bus.func_b, bus.func_c}), 32'd4);
        #2;
        seen = n_done;
        rst_n = 1'b0;
        #1;
        check("abort busy",       32'(bus.busy),       32'd0);
        check("abort vector",     32'({bus.func_a, bus.func_b, bus.func_c}), 32'd0);
        check("abort tt_out",     32'(bus.tt_out),     32'd0);
        check("abort ones_count", 32'(bus.ones_count), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #2;
        check("abort no done", 32'(n_done - seen), 32'd0);
        run_sweep("after reset", 25, 8'h61, 4'd3, 1'b0, 3'd0, 1'b1, 0);

        // Extra start while busy, then start during DONE: both ignored.
        run_sweep("busy poke", 25, 8'h61, 4'd3, 1'b0, 3'd0, 1'b1, 5);
        run_sweep("done poke", 25, 8'h61, 4'd3, 1'b0, 3'd0, 1'b1, 25);

        // Start held high: back-to-back sweeps separated by a single IDLE cycle.
        first = 0;
        second = 0;
        bus.start = 1'b1;
        for (int c = 1; c <= 120 && second == 0; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (first == 0) first = c;
                else second = c;
            end
            if (first != 0 && c == first + 1) check("held idle gap busy", 32'(bus.busy), 32'd0);
        end
        #2 bus.start = 1'b0;
        check("held first latency",   32'(first),          32'd25);
        check("held restart spacing", 32'(second - first), 32'd26);
        repeat (3) @(negedge clk);
        #2;
        check("held final idle", 32'(bus.busy), 32'd0);
        check("held final pass", 32'(bus.pass), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
